// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared types and field positions for the pico fetch sequencer.
package pc_fetch_pkg;
  typedef enum logic [1:0] {INCREMENT = 2'd0, RELATIVE = 2'd1, HALTCOUNT = 2'd2} modePC;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EXEC, HALTED} fetchState;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RETIRED_W = 16;
endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: instruction-memory req/gnt/rvalid handshake.
interface pc_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 32
);
  logic req;
  logic [ADDR_W-1:0] addr;
  logic gnt;
  logic rvalid;
  logic [INSTR_W-1:0] rdata;
  modport master(output req, addr, input gnt, rvalid, rdata);
  modport slave(input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/pc_fetch_pc_next.sv
// pc_next: next-PC from mode and offset; the offset is already PC-wide so the modulo add sign-extends and wraps.
module pc_next import pc_fetch_pkg::*; #(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  modePC mode,
  input  logic [ADDR_W-1:0] offset,
  input  logic halt,
  output logic [ADDR_W-1:0] next_pc,
  output logic stop
);
  always_comb begin
    stop = halt || !(mode inside {INCREMENT, RELATIVE});
    next_pc = stop ? pc : mode == RELATIVE ? pc + offset : pc + ADDR_W'(1);
  end
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and fetch sequencer; hands one instruction at a time to the decoder.
module pc_fetch import pc_fetch_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  modePC mode_pc_i,
  input  logic [ADDR_W-1:0] offset_i,
  input  logic halt_core_i,
  pc_fetch_if.master imem,
  output logic [INSTR_W-1:0] instr_o,
  output logic instr_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic halted_o,
  output logic [RETIRED_W-1:0] retired_o
);
  fetchState state;
  logic [ADDR_W-1:0] next_pc;
  logic stop;
  logic [1:0] since_rst;
  pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc(pc_o),
    .mode(mode_pc_i),
    .offset(offset_i),
    .halt(halt_core_i),
    .next_pc(next_pc),
    .stop(stop)
  );
  assign imem.req = state == FETCH;
  assign imem.addr = pc_o;
  assign instr_valid_o = state == EXEC;
  assign halted_o = state == IDLE || state == HALTED;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      pc_o <= RESET_PC;
      instr_o <= '0;
      retired_o <= '0;
    end else begin
      case (state)
        IDLE, HALTED: if (run_i) begin
          pc_o <= RESET_PC;
          state <= FETCH;
        end
        FETCH: if (imem.gnt) begin
          if (imem.rvalid) instr_o <= imem.rdata;
          state <= imem.rvalid ? EXEC : WAIT;
        end
        WAIT: if (imem.rvalid) begin
          instr_o <= imem.rdata;
          state <= EXEC;
        end
        EXEC: begin
          retired_o <= retired_o + RETIRED_W'(1);
          pc_o <= next_pc;
          state <= stop ? HALTED : FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // a read started before reset may still land shortly after release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) since_rst <= '0;
    else if (since_rst != 2'd3) since_rst <= since_rst + 2'd1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_ni && state == EXEC)
      assert (mode_pc_i inside {INCREMENT, RELATIVE, HALTCOUNT})
      else $error("pc_fetch: undefined mode_pc_i in EXEC, treated as HALTCOUNT");
    if (rst_ni && halted_o && since_rst == 2'd3)
      assert (!imem.rvalid)
      else $error("pc_fetch: rvalid while idle or halted");
  end
endmodule
